bcd_ascii_streamer: RTL and testbench
=====================================

# bcd_ascii_streamer

Sequencer that takes a multi-digit packed BCD value and emits it as a stream of ASCII characters over a valid/ready byte interface. Output is most-significant digit first, with optional leading-zero suppression and an optional CR/LF terminator. Sits between the counter/display datapath, which produces BCD digits, and a byte sink such as a UART transmitter or LCD writer. Contains the per-digit BCD-to-ASCII conversion and controls which digit is presented to it each step.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits in `bcd_in` (1..8).
- SUPPRESS_ZEROS, 1, when 1, leading zero digits are skipped; the least-significant digit is always sent.
- APPEND_CRLF, 1, when 1, 0x0D then 0x0A are sent after the last digit.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request to send; sampled only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD value; digit DIGITS-1 is in the top nibble and is the MSD.
- busy  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- tx_data  out  8  ASCII character, registered; held stable while `tx_valid` && !`tx_ready`.
- tx_valid  out  1  character available.
- tx_ready  in  1  sink accepts; a transfer occurs on an edge where `tx_valid` && `tx_ready`.
- done  out  1  one-cycle pulse after the final character is transferred.

## Operation
- States: IDLE, SELECT, SEND, CR, LF, DONE.
- IDLE: if `start`=1, latch `bcd_in` into the shadow register, set idx=DIGITS-1, clear seen_nz, and go to SELECT. `start` outside IDLE is ignored; no queuing.
- SELECT (1 cycle per digit): take nibble d=shadow[idx].
  - Skip when SUPPRESS_ZEROS=1 && d==0 && !seen_nz && idx!=0. A skip decrements idx and stays in SELECT; no character is emitted.
  - Otherwise, load tx_data = ascii(d), set tx_valid=1, set seen_nz=1, and go to SEND.
- ascii(d): 0..9 map to 0x30..0x39. Invalid nibbles 0xA..0xF map to 0x30, but are treated as nonzero for suppression.
- SEND: wait for the handshake. On the transfer edge, tx_valid is deasserted.
  - If idx!=0: decrement idx and go to SELECT.
  - Else, with APPEND_CRLF=1: go to CR, with tx_data=0x0D and tx_valid=1.
  - Else: go to DONE.
- CR: on transfer, go to LF with tx_data=0x0A and tx_valid=1.
- LF: on transfer, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE.
- The shadow register isolates the block from `bcd_in` changes after acceptance.
- tx_valid never drops without a transfer, and tx_data never changes while tx_valid=1 and tx_ready=0.

## Timing
- Reset values: state=IDLE; busy=0, tx_valid=0, tx_data=0x00, done=0; shadow=0, idx=0, seen_nz=0.
- Reset asserted mid-stream aborts immediately: outputs return to reset values, no done pulse, and a partially sent string is not resumed.
- `start` is accepted at edge E0, and busy=1 after E0.
- The first SELECT cycle runs between E0 and E1. With no skips, tx_valid=1 after E1.
- Each skipped digit adds 1 cycle of latency before the first character.
- With tx_ready held high, throughput is 1 digit character per 2 cycles (SELECT + SEND). CR follows its preceding transfer immediately with tx_valid, as does LF.
- After the last transfer edge: done=1 for 1 cycle (DONE), then busy=0 in IDLE. A new `start` can be accepted in the first IDLE cycle.
- Total cycles from accept to done with tx_ready=1, DIGITS=4, no skips, CRLF: 4×2 + 2 + 1 = 11.

## Test plan
- DIGITS=4, SUPPRESS=1, CRLF=1, bcd_in=16'h0305, tx_ready=1 -> bytes 0x33,0x30,0x35,0x0D,0x0A; one done pulse; first tx_valid 2 cycles after the start edge, since one digit is skipped.
- bcd_in=16'h0000, SUPPRESS=1 -> exactly 0x30,0x0D,0x0A (LSD always sent). With SUPPRESS=0 -> 0x30 ×4 then 0x0D,0x0A.
- bcd_in=16'h1234, tx_ready toggling 0,0,1 pseudo-randomly -> bytes 0x31,0x32,0x33,0x34,0x0D,0x0A; tx_data stable while stalled; no byte lost or duplicated.
- bcd_in=16'h0A09 -> 0x30,0x30,0x39 plus CRLF. Invalid nibble A emits 0x30 and ends suppression.
- start pulsed while busy and bcd_in changed mid-stream -> output still reflects the value latched at acceptance; only one done pulse.
- rst asserted while in SEND with tx_ready=0 -> tx_valid=0, busy=0, done=0 immediately. After release, start with 16'h0042 -> 0x34,0x32,0x0D,0x0A.

Source files
------------

// File: rtl/bcd_ascii_streamer.sv
// bcd_ascii_streamer: emits a packed BCD value as ASCII characters, most
// significant digit first, over a byte stream. Leading zeros can be dropped
// and a CR/LF pair can be appended after the last digit.
//
// Byte stream handshake: tx_valid/tx_data are registered. A character moves
// on a rising edge where tx_valid && tx_ready. Once tx_valid is raised it stays
// high, and tx_data stays unchanged, until that transfer edge.
module bcd_ascii_streamer #(
    parameter int DIGITS         = 4,
    parameter int SUPPRESS_ZEROS = 1,
    parameter int APPEND_CRLF    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  done,
    output logic [2:0]            dbg_state
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SEND   = 3'd2;
    localparam logic [2:0] S_CR     = 3'd3;
    localparam logic [2:0] S_LF     = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]          r_state;
    logic [4*DIGITS-1:0] r_shadow;
    logic [IW-1:0]       r_idx;
    logic                r_seen_nz;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;

    logic [3:0]          w_nib;
    logic [7:0]          w_ascii;
    logic                w_skip;
    logic                w_xfer;

    // Current digit, its ASCII code, and whether it is a suppressed leading zero.
    // Invalid nibbles print as '0' but still count as nonzero for suppression.
    always_comb begin
        w_nib   = r_shadow[{r_idx, 2'b00} +: 4];
        w_ascii = (w_nib <= 4'd9) ? {4'h3, w_nib} : 8'h30;
        w_skip  = (SUPPRESS_ZEROS != 0) && (w_nib == 4'd0) && !r_seen_nz
                  && (r_idx != '0);
        w_xfer  = r_tx_valid && tx_ready;
    end

    // Sequencer: digit selection, character load, and handshake tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_seen_nz  <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shadow  <= bcd_in;
                        r_idx     <= LAST_IDX;
                        r_seen_nz <= 1'b0;
                        r_state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_skip) begin
                        r_idx <= r_idx - 1'b1;
                    end else begin
                        r_tx_data  <= w_ascii;
                        r_tx_valid <= 1'b1;
                        r_seen_nz  <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_idx != '0) begin
                            r_idx      <= r_idx - 1'b1;
                            r_tx_valid <= 1'b0;
                            r_state    <= S_SELECT;
                        end else if (APPEND_CRLF != 0) begin
                            // CR goes out back-to-back with the last digit.
                            r_tx_data <= 8'h0D;
                            r_state   <= S_CR;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_CR: begin
                    if (w_xfer) begin
                        r_tx_data <= 8'h0A;
                        r_state   <= S_LF;
                    end
                end
                S_LF: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        tx_data   = r_tx_data;
        tx_valid  = r_tx_valid;
        dbg_state = r_state;
    end

endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// Directed testbench for bcd_ascii_streamer: default instance (suppression and
// CR/LF on) plus a second instance with suppression off.
module tb_bcd_ascii_streamer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;
    logic [2:0]  dbg_state;

    logic        start_b;
    logic [15:0] bcd_b;
    logic        busy_b;
    logic [7:0]  tx_data_b;
    logic        tx_valid_b;
    logic        ready_b;
    logic        done_b;
    logic [2:0]  dbg_state_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    bcd_ascii_streamer #(.DIGITS(4), .SUPPRESS_ZEROS(1), .APPEND_CRLF(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .dbg_state (dbg_state)
    );

    bcd_ascii_streamer #(.DIGITS(4), .SUPPRESS_ZEROS(0), .APPEND_CRLF(1)) dut_nz (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .bcd_in    (bcd_b),
        .busy      (busy_b),
        .tx_data   (tx_data_b),
        .tx_valid  (tx_valid_b),
        .tx_ready  (ready_b),
        .done      (done_b),
        .dbg_state (dbg_state_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one string on the chosen instance. mode 0: sink always ready;
    // mode 1: sink ready roughly one cycle in three. Iteration i samples the
    // outputs between start-edge+i and start-edge+i+1. poke re-pulses start
    // and changes bcd_in mid-stream.
    task automatic run_case(input int unit, input logic [15:0] val, input int mode,
                            input int exp_first, input int exp_done, input bit poke,
                            input string tag);
        int first   = -1;
        int done_at = -1;
        int done_cnt = 0;
        logic v, dn, b, r;
        logic [7:0] d;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [7:0] pd = 8'h00;
        got_q.delete();
        @(negedge clk);
        if (unit == 0) begin bcd_in = val; start = 1'b1; end
        else begin bcd_b = val; start_b = 1'b1; end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start   = 1'b0;
            start_b = 1'b0;
            if (poke && i == 3) begin
                start  = 1'b1;
                bcd_in = 16'h9999;
            end
            r = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 2);
            tx_ready = r;
            ready_b  = r;
            #1;
            if (unit == 0) begin v = tx_valid; d = tx_data; dn = done; b = busy; end
            else begin v = tx_valid_b; d = tx_data_b; dn = done_b; b = busy_b; end
            if (i == 0) check({tag, "_busy_after_accept"}, b, 1);
            if (done_at >= 0) begin
                check({tag, "_busy_idle"}, b, 0);
                check({tag, "_done_one_cycle"}, dn, 0);
                break;
            end
            if (pv && !pr) begin
                check({tag, "_stall_valid"}, v, 1);
                check({tag, "_stall_data"}, d, pd);
            end
            if (v && r) got_q.push_back(d);
            if (v && first < 0) first = i;
            if (dn) begin
                done_cnt++;
                done_at = i;
            end
            pv = v; pd = d; pr = r;
        end
        check({tag, "_done_seen"}, (done_at >= 0), 1);
        check({tag, "_done_count"}, done_cnt, 1);
        if (exp_first >= 0) check({tag, "_first_valid"}, first, exp_first);
        if (exp_done >= 0) check({tag, "_done_cycle"}, done_at, exp_done);
        check({tag, "_byte_count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s_byte%0d", tag, k), got_q[k], exp_q[k]);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; bcd_in = 16'h0000; tx_ready = 1'b0;
        start_b = 1'b0; bcd_b = 16'h0000; ready_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", tx_valid, 0);
        check("reset_data", tx_data, 8'h00);
        check("reset_done", done, 0);
        check("reset_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;

        // One leading zero skipped
        exp_q = {8'h33, 8'h30, 8'h35, 8'h0D, 8'h0A};
        run_case(0, 16'h0305, 0, 2, 9, 1'b0, "v0305");

        // All zeros: LSD always sent
        exp_q = {8'h30, 8'h0D, 8'h0A};
        run_case(0, 16'h0000, 0, 4, 7, 1'b0, "v0000_sup");

        // All zeros with suppression off
        exp_q = {8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        run_case(1, 16'h0000, 0, 1, 10, 1'b0, "v0000_nosup");

        // Back-pressure from the sink
        exp_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        run_case(0, 16'h1234, 1, 1, -1, 1'b0, "v1234_stall");

        // Invalid nibble ends suppression and prints as '0'
        exp_q = {8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};
        run_case(0, 16'h0A09, 0, 2, 9, 1'b0, "v0A09");

        // start and bcd_in disturbed mid-stream
        exp_q = {8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
        run_case(0, 16'h5678, 0, 1, 10, 1'b1, "v5678_poke");
        repeat (3) @(negedge clk);
        #1;
        check("poke_no_requeue_busy", busy, 0);
        check("poke_no_requeue_valid", tx_valid, 0);

        // Reset while stalled in SEND
        @(negedge clk);
        bcd_in = 16'h1234; start = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_valid", tx_valid, 1);
        check("pre_reset_state", dbg_state, 2);
        rst = 1'b1;
        #1;
        check("midrst_valid", tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_data", tx_data, 8'h00);
        check("midrst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", tx_valid, 0);

        exp_q = {8'h34, 8'h32, 8'h0D, 8'h0A};
        run_case(0, 16'h0042, 0, 3, 8, 1'b0, "v0042");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
